// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch: FSM encoding, BCD limits, BCD increment helper.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  localparam logic [3:0] BCD_DIGIT_MAX    = 4'd9;
  localparam logic [3:0] BCD_SEC_TENS_MAX = 4'd5;
  localparam int         DEB_CNT_W        = 8;

  typedef struct packed {
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic [3:0] hund_tens;
    logic [3:0] hund_ones;
  } bcd_time_t;

  // Ripple-carry BCD increment; 59.99 wraps to 00.00.
  function automatic bcd_time_t bcd_inc(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.hund_ones != BCD_DIGIT_MAX) begin
      r.hund_ones = t.hund_ones + 4'd1;
    end else begin
      r.hund_ones = 4'd0;
      if (t.hund_tens != BCD_DIGIT_MAX) begin
        r.hund_tens = t.hund_tens + 4'd1;
      end else begin
        r.hund_tens = 4'd0;
        if (t.sec_ones != BCD_DIGIT_MAX) begin
          r.sec_ones = t.sec_ones + 4'd1;
        end else begin
          r.sec_ones = 4'd0;
          if (t.sec_tens != BCD_SEC_TENS_MAX) r.sec_tens = t.sec_tens + 4'd1;
          else                                r.sec_tens = 4'd0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic bcd_is_max(input bcd_time_t t);
    return (t.sec_tens == BCD_SEC_TENS_MAX) && (t.sec_ones == BCD_DIGIT_MAX) &&
           (t.hund_tens == BCD_DIGIT_MAX) && (t.hund_ones == BCD_DIGIT_MAX);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: 2-flop sync, ce1ms-timed debounce, one-clk press pulse on debounced rise.
// Latency: 2 clk + DEB_MS ce1ms ticks + 1 clk from press to pulse; no backpressure.
module btn_debounce
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEB_MS = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic ce1ms,
  input  logic btn,
  output logic press
);

  localparam logic [DEB_CNT_W-1:0] DEB_LAST = DEB_CNT_W'(DEB_MS - 1);

  logic                 sync1;
  logic                 sync2;
  logic                 deb;
  logic [DEB_CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      deb   <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      press <= 1'b0;
      // Any bounce back to the settled level restarts the stability window.
      if (sync2 == deb) begin
        cnt <= '0;
      end else if (ce1ms) begin
        if (cnt == DEB_LAST) begin
          deb   <= sync2;
          cnt   <= '0;
          press <= sync2;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch core: start/stop/clear FSM with BCD ss.hh counter advancing on ce10ms in RUN.
// Latency: dat/running/ovf registered, update one clk after the qualifying edge; no backpressure.
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEB_MS = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce1ms,
  input  logic        ce10ms,
  input  logic        btn_start,
  input  logic        btn_clr,
  output logic [15:0] dat,
  output logic        running,
  output logic        ovf
);

  logic      start_press;
  logic      clr_press;
  state_t    state_q;
  state_t    state_d;
  bcd_time_t time_q;
  bcd_time_t time_d;
  logic      running_d;
  logic      ovf_d;
  logic      count_en;

  btn_debounce #(.DEB_MS(DEB_MS)) u_start_deb (
    .clk   (clk),
    .rst   (rst),
    .ce1ms (ce1ms),
    .btn   (btn_start),
    .press (start_press)
  );

  btn_debounce #(.DEB_MS(DEB_MS)) u_clr_deb (
    .clk   (clk),
    .rst   (rst),
    .ce1ms (ce1ms),
    .btn   (btn_clr),
    .press (clr_press)
  );

  assign count_en = (state_q == ST_RUN) && ce10ms;
  assign dat      = time_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      time_q  <= '0;
      running <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      state_q <= state_d;
      time_q  <= time_d;
      running <= running_d;
      ovf     <= ovf_d;
    end
  end

  // Clear only acts from PAUSE, and beats a simultaneous start there.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start_press) state_d = ST_RUN;
      ST_RUN:   if (start_press) state_d = ST_PAUSE;
      ST_PAUSE: begin
        if (clr_press)        state_d = ST_IDLE;
        else if (start_press) state_d = ST_RUN;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // A ce10ms that coincides with stop still counts, since the decision uses the current state.
  always_comb begin
    time_d    = time_q;
    ovf_d     = 1'b0;
    running_d = (state_d == ST_RUN);
    if ((state_q == ST_PAUSE) && clr_press) begin
      time_d = '0;
    end else if (count_en) begin
      time_d = bcd_inc(time_q);
      ovf_d  = bcd_is_max(time_q);
    end
  end

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed self-checking bench for stopwatch_core with DEB_MS=2.
module tb_stopwatch_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce1ms;
  logic        ce10ms;
  logic        btn_start;
  logic        btn_clr;
  logic [15:0] dat;
  logic        running;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  stopwatch_core #(.DEB_MS(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .ce1ms     (ce1ms),
    .ce10ms    (ce10ms),
    .btn_start (btn_start),
    .btn_clr   (btn_clr),
    .dat       (dat),
    .running   (running),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic tick_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Hold buttons for hold_ticks ce1ms ticks, then release and let the release debounce.
  // with_ce10 drives ce10ms in the cycle where the press pulse reaches the FSM.
  task automatic press(input logic s, input logic c, input int hold_ticks, input logic with_ce10);
    btn_start = s;
    btn_clr   = c;
    repeat (3) tick_clk();
    for (int i = 0; i < hold_ticks; i++) begin
      ce1ms = 1'b1;
      tick_clk();
      ce1ms  = 1'b0;
      ce10ms = (i == 1) && with_ce10;
      tick_clk();
      ce10ms = 1'b0;
    end
    btn_start = 1'b0;
    btn_clr   = 1'b0;
    repeat (3) tick_clk();
    for (int i = 0; i < 2; i++) begin
      ce1ms = 1'b1;
      tick_clk();
      ce1ms = 1'b0;
      tick_clk();
    end
  endtask

  task automatic count(input int n);
    for (int i = 0; i < n; i++) begin
      ce10ms = 1'b1;
      tick_clk();
      ce10ms = 1'b0;
      tick_clk();
    end
  endtask

  initial begin
    rst = 1'b1; ce1ms = 1'b0; ce10ms = 1'b0; btn_start = 1'b0; btn_clr = 1'b0;
    repeat (2) tick_clk();
    check("reset_dat", dat, 16'h0000);
    check("reset_running", {15'd0, running}, 16'd0);
    check("reset_ovf", {15'd0, ovf}, 16'd0);
    rst = 1'b0;
    tick_clk();

    // Short glitch: one tick only, no press
    press(1'b1, 1'b0, 1, 1'b0);
    check("glitch_running", {15'd0, running}, 16'd0);
    check("glitch_dat", dat, 16'h0000);

    press(1'b1, 1'b0, 3, 1'b0);
    check("start_running", {15'd0, running}, 16'd1);
    check("start_dat", dat, 16'h0000);
    count(150);
    check("count150", dat, 16'h0150);
    press(1'b1, 1'b0, 2, 1'b0);
    check("pause_running", {15'd0, running}, 16'd0);
    check("pause_dat", dat, 16'h0150);
    count(5);
    check("pause_frozen", dat, 16'h0150);

    // Start and clear together in PAUSE: clear wins
    press(1'b1, 1'b1, 2, 1'b0);
    check("both_running", {15'd0, running}, 16'd0);
    check("both_dat", dat, 16'h0000);

    // Start from IDLE with coincident ce10ms: no increment
    press(1'b1, 1'b0, 2, 1'b1);
    check("idle_ce10_running", {15'd0, running}, 16'd1);
    check("idle_ce10_dat", dat, 16'h0000);

    count(200);
    check("count200", dat, 16'h0200);
    press(1'b0, 1'b1, 2, 1'b0);
    check("clr_in_run_running", {15'd0, running}, 16'd1);
    check("clr_in_run_dat", dat, 16'h0200);
    count(1);
    check("clr_in_run_next", dat, 16'h0201);

    // Stop in RUN with coincident ce10ms: increment happens
    press(1'b1, 1'b0, 2, 1'b1);
    check("run_ce10_running", {15'd0, running}, 16'd0);
    check("run_ce10_dat", dat, 16'h0202);
    press(1'b1, 1'b0, 2, 1'b1);
    check("pause_ce10_running", {15'd0, running}, 16'd1);
    check("pause_ce10_dat", dat, 16'h0202);

    count(5796);
    check("count5998", dat, 16'h5998);
    ce10ms = 1'b1;
    tick_clk();
    ce10ms = 1'b0;
    check("dat5999", dat, 16'h5999);
    check("ovf_before", {15'd0, ovf}, 16'd0);
    tick_clk();
    ce10ms = 1'b1;
    tick_clk();
    ce10ms = 1'b0;
    check("wrap_dat", dat, 16'h0000);
    check("wrap_ovf", {15'd0, ovf}, 16'd1);
    check("wrap_running", {15'd0, running}, 16'd1);
    tick_clk();
    check("ovf_one_clk", {15'd0, ovf}, 16'd0);

    // Asynchronous reset mid-RUN
    count(423);
    check("count423", dat, 16'h0423);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_dat", dat, 16'h0000);
    check("async_rst_running", {15'd0, running}, 16'd0);
    tick_clk();
    rst = 1'b0;
    count(3);
    check("post_rst_dat", dat, 16'h0000);
    check("post_rst_running", {15'd0, running}, 16'd0);

    // Button held through reset release needs a full debounce interval
    btn_start = 1'b1;
    rst = 1'b1;
    repeat (2) tick_clk();
    rst = 1'b0;
    repeat (3) tick_clk();
    ce1ms = 1'b1;
    tick_clk();
    ce1ms = 1'b0;
    tick_clk();
    check("held_one_tick_running", {15'd0, running}, 16'd0);
    ce1ms = 1'b1;
    tick_clk();
    ce1ms = 1'b0;
    tick_clk();
    check("held_two_tick_running", {15'd0, running}, 16'd1);
    btn_start = 1'b0;
    count(1);
    check("held_count", dat, 16'h0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stopwatch_core.md
STOPWATCH_CORE -- requirements
Module: stopwatch_core

Interface
REQ-001 Parameter DEB_MS, default 20, SHALL set debounce stability time in ce1ms ticks (1..255).
REQ-002 clk  in  1  system clock; the only clock in the block.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 ce1ms  in  1  one-clk pulse every 1 ms, from the display driver.
REQ-005 ce10ms  in  1  one-clk pulse every 10 ms, from the display driver.
REQ-006 btn_start  in  1  raw start/stop pushbutton, asynchronous, active-high.
REQ-007 btn_clr  in  1  raw clear pushbutton, asynchronous, active-high.
REQ-008 dat  out  16  BCD time {sec_tens, sec_ones, hund_tens, hund_ones}, fed to the display driver.
REQ-009 running  out  1  high while in RUN.
REQ-010 ovf  out  1  one-clk pulse on wrap from 59.99 to 00.00.

Function
REQ-011 Each button SHALL pass a 2-flop synchronizer before any other use.
REQ-012 Debounce: counter clears when synced level equals debounced level; otherwise it increments on ce1ms; on reaching DEB_MS, debounced level takes synced level and counter clears.
REQ-013 A debounced 0->1 transition SHALL produce exactly one one-clk press pulse; releases produce none.
REQ-014 Minimum press-to-pulse latency: 2 clk (sync) + DEB_MS ce1ms ticks + 1 clk.
REQ-015 FSM states: IDLE (value 00.00, stopped), RUN, PAUSE (value held).
REQ-016 Transitions: IDLE--start-->RUN; RUN--start-->PAUSE; PAUSE--start-->RUN; PAUSE--clr-->IDLE (value zeroed same edge); clr ignored in IDLE and RUN.
REQ-017 Same-cycle start and clr pulses: in PAUSE clr wins (go IDLE); elsewhere start acts alone.
REQ-018 Counting: only in RUN, on ce10ms, hundredths BCD 00..99 increments; 99->00 carries into seconds BCD 00..59.
REQ-019 At 59.99 a counting ce10ms SHALL give 00.00, assert ovf that cycle, and stay in RUN.
REQ-020 ce10ms coinciding with start in RUN: the increment SHALL occur, state becomes PAUSE; in IDLE/PAUSE: state becomes RUN, no increment that cycle.
REQ-021 Each BCD digit SHALL never hold a value above 9 (sec_tens never above 5).
REQ-022 dat and running SHALL be registered outputs; dat updates the clk after the ce10ms edge that counts.

Reset
REQ-023 On rst: state IDLE, dat=16'h0000, running=0, ovf=0, synchronizers and debounced levels 0, debounce counters 0.
REQ-024 rst asserted mid-RUN SHALL take effect immediately without waiting for clk; a button held through reset release SHALL produce a press pulse only after a full debounce interval.

Structure
REQ-025 Shared package stopwatch_pkg SHALL hold the state encoding (IDLE/RUN/PAUSE) and BCD limit constants (9, 5).
REQ-026 One sub-module btn_debounce (synchronizer, debounce counter, edge pulse) SHALL be instantiated twice.
REQ-027 BCD counter and FSM SHALL live in stopwatch_core; no second clock, no clock gating; ce inputs used only as enables.

Verification (DEB_MS=2 in simulation)
REQ-028 btn_start high 1 ce1ms tick then low -> no press pulse, state stays IDLE, dat=0000.
REQ-029 btn_start held 3 ce1ms ticks -> one press, running=1; 150 ce10ms -> dat=0150; second press -> running=0, dat frozen at 0150.
REQ-030 Preload run to 59.98, 2 ce10ms -> dat 5999 then 0000 with ovf pulse exactly one clk, running stays 1.
REQ-031 In PAUSE at 0150, start and clr debounced pulses same cycle -> IDLE, dat=0000, running=0.
REQ-032 rst asserted mid-RUN at 0423 between clk edges -> dat=0000, running=0 immediately; after release, ce10ms pulses do not change dat.
REQ-033 clr pressed in RUN at 0200 -> ignored, counting continues to 0201 on next ce10ms.
